ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter; sends 1-byte commands (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard.
//  Shares PS2_CLK/PS2_DATA with the keyboard receiver through open-drain drivers at the top level.
//  rx_inhibit tells the receiver to ignore the line while a transfer is in progress.
// PARAMETERS
//  INHIBIT_CYCLES  12000   clk cycles PS2 clock is held low before start (>=100us at 100MHz)
//  TIMEOUT_CYCLES  200000  max clk cycles between device clock edges / idle wait (2ms at 100MHz)
// PORTS
//  clk         in   1  system clock; only clock
//  reset       in   1  asynchronous, active-low reset
//  tx_data     in   8  byte to send; sampled when tx_valid && tx_ready
//  tx_valid    in   1  request to send tx_data
//  tx_ready    out  1  high in IDLE only
//  tx_done     out  1  1-cycle pulse: device ACKed and line returned idle
//  tx_error    out  1  1-cycle pulse: NACK or timeout
//  busy        out  1  high in every state except IDLE
//  rx_inhibit  out  1  equals busy; receiver ignores edges while high
//  ps2_clk_i   in   1  raw PS2 clock pin level
//  ps2_data_i  in   1  raw PS2 data pin level
//  ps2_clk_oe  out  1  1 = drive PS2 clock low; 0 = release (pulled up)
//  ps2_data_oe out  1  1 = drive PS2 data low; 0 = release
// BEHAVIOUR
//  - Reset: state=IDLE, tx_ready=1, tx_done=tx_error=busy=rx_inhibit=0, ps2_clk_oe=ps2_data_oe=0, counters=0.
//  - ps2_clk_i/ps2_data_i pass a 2-FF synchronizer (reset to 1); fall = prev_s & ~cur_s of synced clock.
//  - Accept: tx_valid&&tx_ready latches {odd parity (~^tx_data), tx_data}; tx_valid while busy ignored.
//  - INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles; then data_oe=1 (start bit), clk_oe=0 -> BITS.
//  - BITS: count device falling edges n=1..11; after edge n:
//      n=1..8 data_oe=~byte[n-1] (LSB first); n=9 data_oe=~parity; n=10 data_oe=0 (stop, released).
//      n=11: sample synced data; 0 -> WAIT_IDLE, 1 -> error (NACK).
//  - WAIT_IDLE: wait synced clock=1 and data=1, then tx_done pulse, -> IDLE (tx_ready high next cycle).
//  - Error: tx_error pulse, clk_oe=data_oe=0, -> IDLE. tx_done and tx_error never both high.
//  - Latency 0xXX accepted -> clk_oe asserted next cycle; minimum 2 cycles from done pulse to next accept.
//  - Edge during INHIBIT ignored (host owns clock). Simultaneous tx_valid with tx_done cycle: not accepted.
//  - Async reset mid-transfer releases both lines immediately; no pulse emitted.
// CONFIGURATION
//  PS2_TX_TIMEOUT_EN defined: watchdog counter clears on each falling edge/state entry in BITS and
//    WAIT_IDLE; reaching TIMEOUT_CYCLES -> tx_error pulse, lines released, -> IDLE.
//  Not defined: no watchdog; BITS/WAIT_IDLE wait indefinitely; counter logic not synthesized.
// TESTING
//  1 send 0xED, device model clocks 11 edges, ACK=0 -> data bits 1,0,1,1,0,1,1,1, parity 1, one tx_done.
//  2 send 0xF4 -> bits 0,0,1,0,1,1,1,1, parity 0; clk_oe high exactly INHIBIT_CYCLES before start.
//  3 send 0x00, device leaves data=1 on edge 11 -> tx_error pulse, no tx_done, lines released.
//  4 (PS2_TX_TIMEOUT_EN) device stops after edge 4 -> tx_error after TIMEOUT_CYCLES; without macro busy stays 1.
//  5 reset low after edge 5 -> clk_oe=data_oe=0, tx_ready=1 asynchronously; next 0xAA sends cleanly.
//  6 tx_valid held with 0x55 during busy -> only first byte sent; 0x55 accepted after tx_ready returns.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter for single-byte keyboard commands.
// Drives open-drain enables for PS2_CLK/PS2_DATA; rx_inhibit masks the receiver
// while a transfer owns the bus.
// Optional watchdog: define PS2_TX_TIMEOUT_EN to abort a stalled transfer after
// TIMEOUT_CYCLES without a device clock edge (the parameter exists only then).
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000
`ifdef PS2_TX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 200000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    output logic       rx_inhibit,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INHIBIT,
        S_BITS,
        S_WAIT_IDLE
    } state_t;

    state_t           state;
    logic [8:0]       frame;      // {odd parity, data}
    logic [3:0]       bit_cnt;    // device falling edges seen so far
    logic [INH_W-1:0] inh_cnt;

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       clk_s;
    logic       data_s;
    logic       clk_fall;

    // Two-flop synchronizers for the raw pins; idle level is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
            clk_prev  <= clk_sync[1];
        end
    end

    assign clk_s    = clk_sync[1];
    assign data_s   = data_sync[1];
    assign clk_fall = clk_prev & ~clk_s;

    assign rx_inhibit = busy;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_hit;

    // Watchdog: counts cycles since the last device edge or state entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (((state == S_BITS) || (state == S_WAIT_IDLE)) && !clk_fall) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end else begin
            wd_cnt <= '0;
        end
    end

    assign wd_hit = (wd_cnt == WD_LAST);
`endif

    // Transfer sequencer: inhibit, start bit, shift on device edges, ACK check
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            frame       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            tx_ready    <= 1'b1;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        frame       <= {~^tx_data, tx_data};
                        inh_cnt     <= '0;
                        tx_ready    <= 1'b0;
                        busy        <= 1'b1;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        state       <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        bit_cnt     <= '0;
                        state       <= S_BITS;
                    end else begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                    end
                end
                S_BITS: begin
                    if (clk_fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt < 4'd9) begin
                            ps2_data_oe <= ~frame[bit_cnt];
                        end else if (bit_cnt == 4'd9) begin
                            ps2_data_oe <= 1'b0;
                        end else if (!data_s) begin
                            state <= S_WAIT_IDLE;
                        end else begin
                            tx_error    <= 1'b1;
                            busy        <= 1'b0;
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end
`ifdef PS2_TX_TIMEOUT_EN
                    else if (wd_hit) begin
                        tx_error    <= 1'b1;
                        busy        <= 1'b0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= S_IDLE;
                    end
`endif
                end
                S_WAIT_IDLE: begin
                    if (clk_s && data_s) begin
                        tx_done <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
`ifdef PS2_TX_TIMEOUT_EN
                    else if (wd_hit) begin
                        tx_error    <= 1'b1;
                        busy        <= 1'b0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= S_IDLE;
                    end
`endif
                end
                default: begin
                    busy        <= 1'b0;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-drain device model.
// Expected line bits are queued when a byte is submitted and popped as the
// device model samples the data line.
module tb_ps2_host_tx;

    localparam int unsigned INH   = 20;
    localparam int unsigned STALL = 400;
`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned TO    = 300;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       busy;
    logic       rx_inhibit;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk;
    logic       dev_data;
    logic       ps2_clk_line;
    logic       ps2_data_line;

    // Open-drain bus: either side may pull low
    assign ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH)
`ifdef PS2_TX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .busy       (busy),
        .rx_inhibit (rx_inhibit),
        .ps2_clk_i  (ps2_clk_line),
        .ps2_data_i (ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    logic sb[$];

    int   n_done = 0, n_err = 0, n_both = 0, cyc = 0;
    int   done_cyc = 0, acc_cyc = 0, run_len = 0, last_run = 0;
    logic pulse_clk_oe = 1'b0, pulse_data_oe = 1'b0, pulse_busy = 1'b0, pulse_ready = 1'b0;
    logic clk_oe_prev = 1'b0;
    int   d0, e0;

    // Pulse monitor and inhibit-length measurement, sampled mid-cycle
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (tx_error) n_err <= n_err + 1;
        if (tx_done && tx_error) n_both <= n_both + 1;
        if (tx_done || tx_error) begin
            pulse_clk_oe  <= ps2_clk_oe;
            pulse_data_oe <= ps2_data_oe;
            pulse_busy    <= busy;
            pulse_ready   <= tx_ready;
        end
        if (ps2_clk_oe) begin
            if (!clk_oe_prev) acc_cyc <= cyc;
            run_len <= run_len + 1;
        end else if (run_len != 0) begin
            last_run <= run_len;
            run_len  <= 0;
        end
        clk_oe_prev <= ps2_clk_oe;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mark();
        d0 = n_done;
        e0 = n_err;
    endtask

    // Line bits after edges 1..10: data LSB first, odd parity, released stop
    task automatic push_exp(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        for (int i = 0; i < 8; i++) sb.push_back(b[i]);
        sb.push_back((ones % 2) == 0);
        sb.push_back(1'b1);
    endtask

    task automatic accept(input logic [7:0] b);
        int k;
        k = 0;
        while (!tx_ready && k < STALL) begin
            tick(1);
            k++;
        end
        chk("ready_before_accept", tx_ready, 1'b1);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        chk("clk_oe_next_cycle", ps2_clk_oe, 1'b1);
        chk("data_released_inhibit", ps2_data_oe, 1'b0);
        chk("busy_after_accept", busy, 1'b1);
        chk("rx_inhibit_after_accept", rx_inhibit, 1'b1);
        chk("ready_low_when_busy", tx_ready, 1'b0);
    endtask

    task automatic inhibit_phase();
        int k;
        k = 0;
        while (ps2_clk_oe && k < int'(INH) + 50) begin
            tick(1);
            k++;
        end
        tick(1);
        chk_n("inhibit_len", last_run, INH);
        chk("start_bit", ps2_data_oe, 1'b1);
    endtask

    // Device: nedges falling clock edges; samples the data line while clock is high
    task automatic device(input logic ack, input int nedges);
        logic e;
        for (int n = 1; n <= nedges; n++) begin
            dev_clk = 1'b0;
            tick(8);
            dev_clk = 1'b1;
            tick(4);
            if (n <= 10) begin
                e = (sb.size() > 0) ? sb.pop_front() : 1'bx;
                chk($sformatf("line_bit_%0d", n), ps2_data_line, e);
            end
            if (n == 10) dev_data = ack;
            tick(4);
        end
        if (nedges == 11) begin
            tick(2);
            dev_data = 1'b1;
        end
    endtask

    task automatic outcome(input logic exp_done);
        int k;
        k = 0;
        while (n_done == d0 && n_err == e0 && k < int'(STALL)) begin
            tick(1);
            k++;
        end
        tick(3);
        chk_n("done_count", n_done - d0, exp_done ? 1 : 0);
        chk_n("error_count", n_err - e0, exp_done ? 0 : 1);
        chk("clk_oe_at_pulse", pulse_clk_oe, 1'b0);
        chk("data_oe_at_pulse", pulse_data_oe, 1'b0);
        chk("busy_at_pulse", pulse_busy, 1'b0);
    endtask

    task automatic send(input logic [7:0] b, input logic ack);
        mark();
        push_exp(b);
        accept(b);
        inhibit_phase();
        device(ack, 11);
        outcome(!ack);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        tick(3);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_tx_done", tx_done, 1'b0);
        chk("rst_tx_error", tx_error, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rx_inhibit", rx_inhibit, 1'b0);
        chk("rst_clk_oe", ps2_clk_oe, 1'b0);
        chk("rst_data_oe", ps2_data_oe, 1'b0);
        reset = 1'b1;
        tick(3);

        // Set-LEDs and enable commands, ACKed
        send(8'hED, 1'b0);
        send(8'hF4, 1'b0);

        // NACK from device
        send(8'h00, 1'b1);

        // Device stalls after edge 4
        mark();
        push_exp(8'hC3);
        accept(8'hC3);
        inhibit_phase();
        device(1'b0, 4);
        sb.delete();
`ifdef PS2_TX_TIMEOUT_EN
        begin
            int k;
            k = 0;
            while (n_err == e0 && k < int'(TO) + 100) begin
                tick(1);
                k++;
            end
            tick(2);
            chk_n("timeout_error_count", n_err - e0, 1);
            chk("timeout_window", (k >= int'(TO) - 30) && (k <= int'(TO) + 5), 1'b1);
            chk("timeout_clk_released", ps2_clk_oe, 1'b0);
            chk("timeout_data_released", ps2_data_oe, 1'b0);
        end
`else
        tick(STALL);
        chk("stall_busy_holds", busy, 1'b1);
        chk_n("stall_no_error", n_err - e0, 0);
        chk_n("stall_no_done", n_done - d0, 0);
`endif
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);

        // Async reset after edge 5 with data line driven low
        mark();
        push_exp(8'h0F);
        accept(8'h0F);
        inhibit_phase();
        device(1'b0, 5);
        sb.delete();
        chk("pre_reset_data_oe", ps2_data_oe, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_clk_oe", ps2_clk_oe, 1'b0);
        chk("async_rst_data_oe", ps2_data_oe, 1'b0);
        chk("async_rst_ready", tx_ready, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        tick(3);
        chk_n("async_rst_no_done", n_done - d0, 0);
        chk_n("async_rst_no_error", n_err - e0, 0);
        reset = 1'b1;
        tick(3);
        send(8'hAA, 1'b0);

        // tx_valid held with a second byte across a whole transfer
        mark();
        push_exp(8'h81);
        accept(8'h81);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        inhibit_phase();
        device(1'b0, 11);
        outcome(1'b1);
        chk("ready_low_at_done", pulse_ready, 1'b0);
        chk_n("done_to_accept_cycles", acc_cyc - done_cyc, 2);
        tx_valid = 1'b0;
        mark();
        push_exp(8'h55);
        inhibit_phase();
        device(1'b0, 11);
        outcome(1'b1);

        tick(5);
        chk_n("never_done_and_error", n_both, 0);
        chk_n("scoreboard_drained", sb.size(), 0);
        chk("final_idle_ready", tx_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
